serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller that computes WIDTH-bit sums by stepping one shared `full_adder` instance through the operands, LSB first, one bit per clock. Operand capture and result delivery use valid/ready handshakes. Between the two handshakes the block sequences the datapath and holds the running carry. It serves area-constrained arithmetic paths where one 1-bit adder replaces a WIDTH-bit ripple chain.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  an operand set is presented.
- `start_ready`  out  1  block can accept operands; high only in IDLE.
- `a_in`  in  WIDTH  operand A; sampled only on the start handshake.
- `b_in`  in  WIDTH  operand B; sampled only on the start handshake.
- `cin_in`  in  1  carry-in; sampled only on the start handshake.
- `result_valid`  out  1  `sum_out` and `cout_out` are valid; high only in DONE.
- `result_ready`  in  1  consumer accepts the result.
- `sum_out`  out  WIDTH  registered sum.
- `cout_out`  out  1  registered final carry.
- `busy`  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `start_ready`=1.
  - On `start_valid && start_ready`: load A and B shift registers; carry register ← `cin_in`; bit counter ← 0; go to RUN.
- **RUN**
  - Each cycle, the full adder receives A[0], B[0] and the carry register.
  - Its sum bit shifts into the MSB of the sum register, which shifts right.
  - The A and B registers shift right.
  - Carry register ← adder carry-out.
  - Counter increments.
  - On the cycle where counter == WIDTH-1, go to DONE. `cout_out` ← final carry.
- **DONE**
  - `result_valid`=1.
  - `sum_out` and `cout_out` hold stable until `result_valid && result_ready`, then go to IDLE.
- Counter width is `$clog2(WIDTH)`. The counter never wraps because it leaves RUN at WIDTH-1.
- The result is (A + B + cin) mod 2^WIDTH, with `cout_out` equal to bit WIDTH of the full sum.
- `start_valid` asserted in RUN or DONE is ignored, and the operands are not sampled. The requester must keep `start_valid` high until `start_ready` is high.
- `result_ready` asserted outside DONE has no effect.
- `sum_out` carries partial shift contents outside DONE; it is meaningful only when `result_valid`=1.

## Timing
- Reset (asynchronous, any state): state=IDLE; `start_ready`=1; `result_valid`=0; `busy`=0; `sum_out`=0; `cout_out`=0; carry register and counter=0.
- Reset in RUN or DONE abandons the operation; no result is produced.
- Start handshake at edge 0: RUN during cycles 1..WIDTH. `result_valid` rises after edge WIDTH, i.e. latency is WIDTH cycles from accept to valid.
- With `result_ready` held high, the result is consumed at edge WIDTH+1, giving IDLE after it. The next start can be accepted at edge WIDTH+2, so sustained throughput is one operation per WIDTH+2 cycles.
- The result handshake and the next start cannot occur in the same cycle, because `start_ready`=0 in DONE.
- Backpressure: while `result_ready`=0 in DONE, the state, outputs and `busy` hold indefinitely.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.

## Structure
- Shared package `serial_add_pkg`:
  - state enum typedef `serial_add_state_t` {IDLE, RUN, DONE};
  - localparam for the default width.
- One sub-module instance: the existing `full_adder` (a, b, cin, sum, cout), driven from the shift-register LSBs and the carry register.
- Control FSM, counter and shift registers stay in `serial_add_ctrl`.

## Test plan
All scenarios use WIDTH=8.
- Basic add: A=0x5A, B=0x3C, cin=0, `result_ready`=1 → `result_valid` rises 8 cycles after accept; sum=0x96, cout=0.
- Carry chain: A=0xFF, B=0x01, cin=0 → sum=0x00, cout=1.
- Full carry-in: A=0xFF, B=0xFF, cin=1 → sum=0xFF, cout=1.
- Backpressure and busy input:
  - A=0x12, B=0x34; hold `result_ready`=0 for 5 cycles in DONE → sum=0x46 stable and `result_valid`=1 throughout.
  - Drive a second `start_valid` with new operands during RUN and DONE → ignored.
  - Accepted on the first cycle back in IDLE, and its result is correct.
- Reset mid-operation: assert `rst_n`=0 after 3 RUN cycles → all outputs take their reset values immediately. After release, A=0x01, B=0x01 gives sum=0x02, cout=0.
- Back-to-back: four operations with `start_valid` and `result_ready` held high → accept edges spaced exactly 10 cycles apart; all results match a reference model.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller.
// FSM state encoding and default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_add_state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder shared by the serial datapath.
// Pure combinational: sum and carry-out of a, b, cin.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder stepped LSB first,
// one bit per clock, with valid/ready operand and result handshakes.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  serial_add_state_t state;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             fa_sum;
  logic             fa_cout;
  logic             last;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= cin_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // sum bits enter at the MSB so the LSB lands at bit 0 last
          s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          carry <= fa_cout;
          if (last) begin
            cout_q <= fa_cout;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign sum_out      = s_sr;
  assign cout_out     = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl against
// an arithmetic reference: {cout,sum} = a + b + cin.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic     mon_en = 1'b0;
  logic [8:0] got_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a_in         (a_in),
    .b_in         (b_in),
    .cin_in       (cin_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum_out      (sum_out),
    .cout_out     (cout_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (mon_en && result_valid && result_ready)
      got_q.push_back({cout_out, sum_out});

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return 9'(s % 512);
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!start_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ready_timeout", 32'(start_ready), 32'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [7:0] a,
                        input logic [7:0] b,
                        input logic c,
                        input int hold);
    logic [8:0] e;
    int n;
    e = model(a, b, c);
    result_ready = (hold == 0);
    start_valid = 1'b1;
    a_in = a;
    b_in = b;
    cin_in = c;
    wait_ready();
    @(posedge clk); #1;
    start_valid = 1'b0;
    wait_valid(n);
    chk("latency", 32'(n), 32'(W));
    chk("sum", 32'(sum_out), 32'(e[7:0]));
    chk("cout", 32'(cout_out), 32'(e[8]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(result_valid), 32'd1);
      chk("hold_sum", 32'(sum_out), 32'(e[7:0]));
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    chk("consumed", 32'(result_valid), 32'd0);
    chk("idle_ready", 32'(start_ready), 32'd1);
    result_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c_edge;
    int acc[4];
    logic [8:0] exp_q[$];
    logic [7:0] ra;
    logic [7:0] rb;
    logic rc;

    rst_n = 1'b0;
    start_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    cin_in = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    chk("rst_cout", 32'(cout_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h5A, 8'h3C, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);

    // backpressure with a competing start held during RUN and DONE
    start_valid = 1'b1;
    a_in = 8'h12;
    b_in = 8'h34;
    cin_in = 1'b0;
    result_ready = 1'b0;
    wait_ready();
    @(posedge clk); #1;
    a_in = 8'hAA;
    b_in = 8'h55;
    chk("busy_run", 32'(busy), 32'd1);
    wait_valid(n);
    chk("bp_latency", 32'(n), 32'(W));
    chk("bp_sum", 32'(sum_out), 32'h46);
    chk("bp_cout", 32'(cout_out), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(result_valid), 32'd1);
      chk("bp_hold_sum", 32'(sum_out), 32'h46);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_no_start", 32'(start_ready), 32'd0);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    c_edge = cyc;
    chk("bp_back_idle", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_accept_edge", 32'(cyc - c_edge), 32'd1);
    chk("bp_accepted", 32'(busy), 32'd1);
    start_valid = 1'b0;
    wait_valid(n);
    chk("second_latency", 32'(n), 32'(W));
    chk("second_sum", 32'(sum_out), 32'hFF);
    chk("second_cout", 32'(cout_out), 32'd0);
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("second_consumed", 32'(result_valid), 32'd0);

    // reset in the middle of RUN
    start_valid = 1'b1;
    a_in = 8'h77;
    b_in = 8'h99;
    wait_ready();
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(start_ready), 32'd1);
    chk("mid_rst_valid", 32'(result_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum", 32'(sum_out), 32'd0);
    chk("mid_rst_cout", 32'(cout_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom),
             int'($urandom_range(3, 0)));
    end

    // back-to-back with both handshakes held high
    mon_en = 1'b1;
    result_ready = 1'b1;
    start_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      a_in = ra;
      b_in = rb;
      cin_in = rc;
      wait_ready();
      @(posedge clk); #1;
      acc[i] = cyc;
      exp_q.push_back(model(ra, rb, rc));
    end
    start_valid = 1'b0;
    n = 0;
    while (got_q.size() < 4 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_count", 32'(got_q.size()), 32'd4);
    for (int i = 1; i < 4; i++)
      chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'(W + 2));
    for (int i = 0; i < 4; i++)
      if (i < got_q.size())
        chk("b2b_result", 32'(got_q[i]), 32'(exp_q[i]));
    mon_en = 1'b0;
    result_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
